// File: rtl/fp32_to_int.sv
// fp32_to_int: IEEE-754 single-precision to signed integer converter, one shift per cycle.
// Ready/valid handshake on both sides; honours four rounding modes and reports invalid/overflow/inexact.
module fp32_to_int #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [1:0]        rounding_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_invalid,
    output logic              out_overflow,
    output logic              out_inexact
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
    localparam logic [7:0]        E_SAT = 8'(127 + DATA_W - 1);
    localparam logic [DATA_W-1:0] MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    state_t            r_state, w_next;
    logic              r_sign, r_g, r_s, r_left, r_nan, r_sat, r_satf;
    logic [1:0]        r_mode;
    logic [5:0]        r_cnt;
    logic [DATA_W:0]   r_mag;
    logic [7:0]        w_exp, w_ee, w_rd;
    logic [23:0]       w_sig;
    logic [5:0]        w_n;
    logic              w_nan, w_big, w_exc, w_byp, w_left, w_accept, w_inc, w_of;
    logic [DATA_W:0]   w_rnd, w_lim;
    logic [DATA_W-1:0] w_res;
    assign w_exp    = in_data[30:23];
    assign w_ee     = (w_exp == 8'd0) ? 8'd1 : w_exp;
    assign w_sig    = {|w_exp, in_data[22:0]};
    assign w_nan    = (&w_exp) & (|in_data[22:0]);
    assign w_big    = w_exp >= E_SAT;
    // -2^(DATA_W-1) itself is representable, so it bypasses without the overflow flag
    assign w_exc    = in_data[31] & (w_exp == E_SAT) & ~|in_data[22:0];
    assign w_byp    = w_nan | w_big;
    assign w_left   = w_ee >= 8'd150;
    assign w_rd     = 8'd150 - w_ee;
    assign w_n      = w_byp ? 6'd0 : w_left ? 6'(w_ee - 8'd150) : (w_rd > 8'd26) ? 6'd26 : w_rd[5:0];
    assign w_accept = in_valid & in_ready;
    assign w_inc    = (r_mode == 2'd0) ? r_g & (r_s | r_mag[0]) :
                      (r_mode == 2'd1) ? 1'b0 :
                      (r_mode == 2'd2) ? ~r_sign & (r_g | r_s) : r_sign & (r_g | r_s);
    assign w_rnd    = r_mag + (DATA_W+1)'(w_inc);
    assign w_lim    = {2'b00, {(DATA_W-1){1'b1}}} + (DATA_W+1)'(r_sign);
    assign w_of     = w_rnd > w_lim;
    assign w_res    = r_nan ? MAX : (r_sat | w_of) ? (r_sign ? MIN : MAX) :
                      r_sign ? -w_rnd[DATA_W-1:0] : w_rnd[DATA_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)  ? (w_accept ? ((w_n == 6'd0) ? ROUND : SHIFT) : IDLE) :
                 (r_state == SHIFT) ? ((r_cnt == 6'd1) ? ROUND : SHIFT) :
                 (r_state == ROUND) ? DONE : (out_ready ? IDLE : DONE);
    end
    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign       <= 1'b0;
            r_mode       <= 2'd0;
            r_mag        <= '0;
            r_g          <= 1'b0;
            r_s          <= 1'b0;
            r_cnt        <= 6'd0;
            r_left       <= 1'b0;
            r_nan        <= 1'b0;
            r_sat        <= 1'b0;
            r_satf       <= 1'b0;
            out_data     <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= in_data[31];
                r_mode <= rounding_mode;
                r_mag  <= w_byp ? '0 : {{(DATA_W-23){1'b0}}, w_sig};
                r_g    <= 1'b0;
                r_s    <= 1'b0;
                r_cnt  <= w_n;
                r_left <= w_left;
                r_nan  <= w_nan;
                r_sat  <= w_big & ~w_nan;
                r_satf <= ~w_exc;
            end else if (r_state == SHIFT) begin
                r_mag <= r_left ? r_mag << 1 : r_mag >> 1;
                r_g   <= r_left ? r_g : r_mag[0];
                r_s   <= r_left ? r_s : r_s | r_g;
                r_cnt <= r_cnt - 6'd1;
            end
            if (r_state == ROUND) begin
                out_data     <= w_res;
                out_invalid  <= r_nan;
                out_overflow <= r_sat ? r_satf : w_of;
                out_inexact  <= r_g | r_s;
            end
        end
    end
endmodule

// File: tb/tb_fp32_to_int.sv
// tb_fp32_to_int: directed vectors with hand-computed results for the 32-bit converter.
module tb_fp32_to_int;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  rounding_mode;
    logic        out_invalid, out_overflow, out_inexact;
    int          checks = 0;
    int          errors = 0;

    fp32_to_int #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rounding_mode(rounding_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_invalid(out_invalid),
        .out_overflow(out_overflow), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lat = posedges from the acceptance edge up to the first edge that sees out_valid high
    task automatic op(input string tag, input logic [31:0] d, input logic [1:0] m,
                      input logic [31:0] ed, input logic ei, input logic eo, input logic ex,
                      input int el, input bit bp);
        int lat;
        logic [31:0] hd;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        out_ready     = ~bp;
        in_data       = d;
        rounding_mode = m;
        in_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid      = 1'b0;
        in_data       = 32'hFFFF_FFFF;
        rounding_mode = 2'($urandom_range(0, 3));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(el));
        chk({tag, ".data"}, 64'(out_data), 64'(ed));
        chk({tag, ".flags"}, 64'({out_invalid, out_overflow, out_inexact}), 64'({ei, eo, ex}));
        if (bp) begin
            hd = out_data;
            repeat (5) begin
                @(negedge clk);
                chk({tag, ".hold"}, 64'({out_valid, in_ready, out_data, out_invalid, out_overflow, out_inexact}),
                    64'({1'b1, 1'b0, hd, ei, eo, ex}));
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk({tag, ".release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; rounding_mode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.hs", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        chk("reset.out", 64'({out_data, out_invalid, out_overflow, out_inexact}), 64'd0);

        op("p2.5_rne",  32'h4020_0000, 2'd0, 32'h0000_0002, 0, 0, 1, 24, 0);
        op("m2.5_ninf", 32'hC020_0000, 2'd3, 32'hFFFF_FFFD, 0, 0, 1, 24, 0);
        op("m2.5_pinf", 32'hC020_0000, 2'd2, 32'hFFFF_FFFE, 0, 0, 1, 24, 0);
        op("m2.5_rz",   32'hC020_0000, 2'd1, 32'hFFFF_FFFE, 0, 0, 1, 24, 0);
        op("p2^31",     32'h4F00_0000, 2'd0, 32'h7FFF_FFFF, 0, 1, 0, 2, 0);
        op("m2^31",     32'hCF00_0000, 2'd0, 32'h8000_0000, 0, 0, 0, 2, 0);
        op("minf",      32'hFF80_0000, 2'd0, 32'h8000_0000, 0, 1, 0, 2, 0);
        op("pinf",      32'h7F80_0000, 2'd1, 32'h7FFF_FFFF, 0, 1, 0, 2, 0);
        op("qnan",      32'h7FC0_0000, 2'd0, 32'h7FFF_FFFF, 1, 0, 0, 2, 0);
        op("pzero",     32'h0000_0000, 2'd0, 32'h0000_0000, 0, 0, 0, 28, 0);
        op("mzero",     32'h8000_0000, 2'd2, 32'h0000_0000, 0, 0, 0, 28, 0);
        op("p1.5_rne",  32'h3FC0_0000, 2'd0, 32'h0000_0002, 0, 0, 1, 25, 0);
        op("p0.5_rne",  32'h3F00_0000, 2'd0, 32'h0000_0000, 0, 0, 1, 26, 0);
        op("p0.5_pinf", 32'h3F00_0000, 2'd2, 32'h0000_0001, 0, 0, 1, 26, 0);
        op("m1.0",      32'hBF80_0000, 2'd0, 32'hFFFF_FFFF, 0, 0, 0, 25, 0);
        op("p2^23",     32'h4B00_0000, 2'd0, 32'h0080_0000, 0, 0, 0, 2, 0);
        op("p2^29",     32'h4E00_0000, 2'd3, 32'h2000_0000, 0, 0, 0, 8, 0);
        op("mbig",      32'hCEFF_FFFF, 2'd0, 32'h8000_0080, 0, 0, 0, 9, 0);
        op("denorm_pi", 32'h0000_0001, 2'd2, 32'h0000_0001, 0, 0, 1, 28, 0);
        op("denorm_ni", 32'h0000_0001, 2'd3, 32'h0000_0000, 0, 0, 1, 28, 0);
        op("backpres",  32'h4020_0000, 2'd0, 32'h0000_0002, 0, 0, 1, 24, 1);

        @(negedge clk);
        in_data = 32'h4020_0000; rounding_mode = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.hs", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
        chk("midrst.out", 64'({out_data, out_invalid, out_overflow, out_inexact}), 64'd0);
        repeat (30) @(negedge clk);
        chk("midrst.quiet", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

        op("after_rst", 32'hBF80_0000, 2'd1, 32'hFFFF_FFFF, 0, 0, 0, 25, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
